// File: rtl/tlc_pkg.sv
// Shared types for the multi-approach traffic light controller.
package tlc_pkg;

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    GRN    = 3'd1,
    YEL    = 3'd2,
    EMG    = 3'd3,
    FLSH   = 3'd4
  } phase_e;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;
  localparam logic [1:0] L_FLS = 2'b11;

  // Index width for an approach number; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase down-counter: load wins, otherwise decrement on en and park at zero.
module tlc_phase_timer #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Counter register; holding at zero lets EMG/FLSH sit with cnt=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= RST_VAL;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tlc_multi.sv
// N-approach traffic light controller: green rotation, walk extension,
// emergency pre-emption and flashing-red fail-safe.
module tlc_multi import tlc_pkg::*; #(
  parameter int N_APPR  = 2,
  parameter int CNT_W   = 4,
  parameter int GRN_T   = 8,
  parameter int YEL_T   = 3,
  parameter int ARD_T   = 2,
  parameter int PED_EXT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_APPR-1:0]         ped_req,
  input  logic                      emg_req,
  input  logic [idx_w(N_APPR)-1:0]  emg_dir,
  input  logic                      flash,
  output logic [2*N_APPR-1:0]       light,
  output logic [N_APPR-1:0]         ped_walk,
  output logic [2:0]                phase,
  output logic [idx_w(N_APPR)-1:0]  active,
  output logic [CNT_W-1:0]          cnt
);

  localparam int             IDX_W = idx_w(N_APPR);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_APPR - 1);

  phase_e                state, state_n;
  logic [IDX_W-1:0]      act_n, nxt;
  logic [N_APPR-1:0]     lat, lat_n, nxt_oh, walk_n;
  logic [2*N_APPR-1:0]   light_n;
  logic [CNT_W-1:0]      ld_val;
  logic                  ld, zero, entering, ext;

  assign nxt    = (active == LAST) ? '0 : active + IDX_W'(1);
  assign nxt_oh = N_APPR'(1) << nxt;
  // A request arriving on the very cycle its green starts is served by it.
  assign ext    = lat[nxt] | ped_req[nxt];
  assign phase  = state;

  tlc_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(ARD_T - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (ld),
    .load_val (ld_val),
    .cnt      (cnt),
    .zero     (zero)
  );

  // Next phase, owner and timer reload; flash yields to emergency and EMG.
  always_comb begin
    state_n  = state;
    act_n    = active;
    ld       = 1'b0;
    ld_val   = '0;
    entering = 1'b0;
    if (en) begin
      if (flash && !emg_req && state != EMG && state != FLSH) begin
        state_n = FLSH;
        ld      = 1'b1;
      end else begin
        case (state)
          ALLRED: if (zero) begin
            ld = 1'b1;
            if (emg_req) begin
              state_n = EMG;
              act_n   = emg_dir;
            end else begin
              state_n  = GRN;
              act_n    = nxt;
              entering = 1'b1;
              ld_val   = ext ? CNT_W'(GRN_T + PED_EXT - 1) : CNT_W'(GRN_T - 1);
            end
          end
          GRN: begin
            if (emg_req && active == emg_dir) begin
              state_n = EMG;
              ld      = 1'b1;
            end else if (emg_req || zero) begin
              state_n = YEL;
              ld      = 1'b1;
              ld_val  = CNT_W'(YEL_T - 1);
            end
          end
          YEL: if (zero) begin
            state_n = ALLRED;
            ld      = 1'b1;
            ld_val  = CNT_W'(ARD_T - 1);
          end
          EMG: if (!emg_req) begin
            state_n = YEL;
            ld      = 1'b1;
            ld_val  = CNT_W'(YEL_T - 1);
          end
          FLSH: if (!flash || emg_req) begin
            state_n = ALLRED;
            ld      = 1'b1;
            ld_val  = CNT_W'(ARD_T - 1);
          end
          default: state_n = ALLRED;
        endcase
      end
    end
  end

  // Walk latches capture even when frozen; entering a green consumes its own.
  always_comb begin
    lat_n  = (lat | ped_req) & ~(entering ? nxt_oh : '0);
    walk_n = '0;
    if (entering)            walk_n = ext ? nxt_oh : '0;
    else if (state_n == GRN) walk_n = ped_walk;
  end

  // Lamp decode from the next state so the lamps register alongside the phase.
  for (genvar i = 0; i < N_APPR; i++) begin : g_lamp
    assign light_n[2*i +: 2] =
      (state_n == FLSH)                     ? L_FLS :
      (act_n != IDX_W'(i))                  ? L_RED :
      (state_n == GRN || state_n == EMG)    ? L_GRN :
      (state_n == YEL)                      ? L_YEL : L_RED;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ALLRED;
      active   <= LAST;
      lat      <= '0;
      light    <= '0;
      ped_walk <= '0;
    end else begin
      state    <= state_n;
      active   <= act_n;
      lat      <= lat_n;
      light    <= light_n;
      ped_walk <= walk_n;
    end
  end

endmodule
